usrt_rx_deser: RTL and testbench

//   USRT receiver and deserializer; the stage directly downstream of the transmitter.

---
 rtl/usrt_rx_deser.sv | 141 ++++++++++++++
 tb/tb_usrt_rx_deser.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_rx_deser.sv
// USRT receiver: synchronizes usrt_clk/rts/txd into clk, deserializes 7/8-bit
// characters LSB first and queues them in a show-ahead FIFO.
module usrt_rx_deser #(
  parameter int DEPTH   = 4,
  parameter int SYNC_FF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usrt_clk,
  input  logic       rts,
  input  logic       txd,
  input  logic       size_sel,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_empty,
  output logic       rd_full,
  output logic       overflow,
  output logic       frame_err,
  input  logic       err_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t             state, state_nxt;
  logic [SYNC_FF-1:0] uclk_sync, rts_sync, txd_sync;
  logic               uclk_d;
  logic               bit_tick, rts_s, txd_s;
  logic               take, abort, drop;
  logic [3:0]         bit_cnt, cnt_inc;
  logic               len8, len8_eff, last;
  logic [6:0]         shreg;
  logic [7:0]         shift_nxt;
  logic               push_r;
  logic [7:0]         word_r;
  logic [7:0]         mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               pop, wr_acc;

  // All three inputs share the same depth so bit/strobe alignment is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uclk_sync <= '0;
      rts_sync  <= '0;
      txd_sync  <= '0;
      uclk_d    <= 1'b0;
    end else begin
      uclk_sync <= {uclk_sync[SYNC_FF-2:0], usrt_clk};
      rts_sync  <= {rts_sync[SYNC_FF-2:0], rts};
      txd_sync  <= {txd_sync[SYNC_FF-2:0], txd};
      uclk_d    <= uclk_sync[SYNC_FF-1];
    end
  end

  assign bit_tick = uclk_sync[SYNC_FF-1] & ~uclk_d;
  assign rts_s    = rts_sync[SYNC_FF-1];
  assign txd_s    = txd_sync[SYNC_FF-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // An rts fall takes priority over a coincident bit_tick.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    abort     = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (rts_s) state_nxt = RECV;
      RECV: begin
        if (!rts_s) begin
          state_nxt = IDLE;
          drop      = 1'b1;
          abort     = (bit_cnt != 4'd0);
        end else if (bit_tick) begin
          take = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign len8_eff  = (bit_cnt == 4'd0) ? size_sel : len8;
  assign cnt_inc   = bit_cnt + 4'd1;
  assign last      = (cnt_inc == (len8_eff ? 4'd8 : 4'd7));
  assign shift_nxt = {txd_s, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      len8    <= 1'b0;
      shreg   <= '0;
      push_r  <= 1'b0;
      word_r  <= '0;
    end else begin
      push_r <= 1'b0;
      if (drop) begin
        bit_cnt <= '0;
      end else if (take) begin
        shreg <= shift_nxt[7:1];
        if (bit_cnt == 4'd0) len8 <= size_sel;
        if (last) begin
          bit_cnt <= '0;
          push_r  <= 1'b1;
          word_r  <= len8_eff ? shift_nxt : {1'b0, shift_nxt[7:1]};
        end else begin
          bit_cnt <= cnt_inc;
        end
      end
    end
  end

  assign rd_empty = (wr_ptr == rd_ptr);
  assign rd_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rd_en & ~rd_empty;
  // When full, a simultaneous pop frees the very slot the push lands in.
  assign wr_acc   = push_r & (~rd_full | pop);
  assign rd_data  = rd_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= word_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      overflow  <= (push_r & rd_full & ~pop) | (overflow & ~err_clr);
      frame_err <= abort | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_usrt_rx_deser.sv
// Directed bench for usrt_rx_deser: framing, latency, 7/8-bit sizing, FIFO
// full/overflow behaviour, sticky error flags and asynchronous reset.
module tb_usrt_rx_deser;
  logic       clk = 1'b0, rst_n = 1'b0, usrt_clk = 1'b0, rts = 1'b0, txd = 1'b0;
  logic       size_sel = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_empty, rd_full, overflow, frame_err;
  int         compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  usrt_rx_deser #(.DEPTH(4), .SYNC_FF(2)) dut (
    .clk(clk), .rst_n(rst_n), .usrt_clk(usrt_clk), .rts(rts), .txd(txd),
    .size_sel(size_sel), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_full(rd_full), .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
  );

  task automatic send_bit(input logic b);
    @(negedge clk) txd = b;
    repeat (3) @(negedge clk);
    usrt_clk = 1'b1;
    repeat (4) @(negedge clk);
    usrt_clk = 1'b0;
  endtask

  // e3/e4: rd_empty 3 and 4 clk after the last rise; optional pop lands on the push cycle
  task automatic send_char(input logic [7:0] d, input int unsigned n, input logic pop_last,
                           output logic e3, output logic e4);
    for (int unsigned i = 0; i < n - 1; i++) send_bit(d[i]);
    @(negedge clk) txd = d[n-1];
    repeat (3) @(negedge clk);
    usrt_clk = 1'b1;
    repeat (3) @(negedge clk);
    e3 = rd_empty;
    if (pop_last) rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    e4 = rd_empty;
    repeat (3) @(negedge clk);
    usrt_clk = 1'b0;
  endtask

  task automatic raise_rts();
    @(negedge clk) rts = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drop_rts();
    @(negedge clk) rts = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    compared++;
    if ({rd_empty, rd_full, overflow, frame_err, rd_data} !== {4'b1000, 8'h00}) begin
      mismatched++;
      $display("FAIL reset: got e/f/ov/fe=%b%b%b%b data=%h, expected 1000 data=00",
               rd_empty, rd_full, overflow, frame_err, rd_data);
    end
  endtask

  task automatic test_char8();
    logic e3, e4;
    size_sel = 1'b1;
    raise_rts();
    send_char(8'hA5, 8, 1'b0, e3, e4);
    compared++;
    if ({e3, e4} !== 2'b10) begin
      mismatched++;
      $display("FAIL latency: empty at +3/+4 clk got %b%b expected 10", e3, e4);
    end
    compared++;
    if (rd_data !== 8'hA5) begin
      mismatched++;
      $display("FAIL char8 data: got %h expected a5", rd_data);
    end
    pop_one();
    compared++;
    if (rd_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL char8 pop: rd_empty got %b expected 1", rd_empty);
    end
    drop_rts();
  endtask

  task automatic test_char7_back_to_back();
    logic e3, e4;
    size_sel = 1'b0;
    raise_rts();
    send_char(8'h55, 7, 1'b0, e3, e4);
    send_char(8'h2A, 7, 1'b0, e3, e4);
    repeat (4) @(negedge clk);
    compared++;
    if (rd_data !== 8'h55) begin
      mismatched++;
      $display("FAIL char7 first: got %h expected 55", rd_data);
    end
    pop_one();
    compared++;
    if (rd_data !== 8'h2A) begin
      mismatched++;
      $display("FAIL char7 second: got %h expected 2a", rd_data);
    end
    pop_one();
    drop_rts();
    compared++;
    if ({rd_empty, frame_err} !== 2'b10) begin
      mismatched++;
      $display("FAIL char7 clean idle: empty/frame_err got %b%b expected 10", rd_empty, frame_err);
    end
  endtask

  task automatic test_frame_err();
    logic       e3, e4;
    logic [7:0] d;
    d = 8'hA5;
    size_sel = 1'b1;
    raise_rts();
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    drop_rts();
    compared++;
    if ({frame_err, rd_empty} !== 2'b11) begin
      mismatched++;
      $display("FAIL frame_err set: frame_err/empty got %b%b expected 11", frame_err, rd_empty);
    end
    pulse_clr();
    compared++;
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_err clear: got %b expected 0", frame_err);
    end
    raise_rts();
    send_char(8'h3C, 8, 1'b0, e3, e4);
    compared++;
    if (rd_data !== 8'h3C) begin
      mismatched++;
      $display("FAIL after abort: got %h expected 3c", rd_data);
    end
    pop_one();
    drop_rts();
  endtask

  task automatic test_size_midchar();
    logic       e3, e4;
    logic [7:0] d;
    d = 8'h5A;
    pop_one();
    compared++;
    if (rd_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL pop while empty: rd_empty got %b expected 1", rd_empty);
    end
    size_sel = 1'b0;
    raise_rts();
    for (int i = 0; i < 7; i++) begin
      send_bit(d[i]);
      if (i == 2) size_sel = 1'b1;
    end
    repeat (6) @(negedge clk);
    compared++;
    if ({rd_empty, rd_data} !== {1'b0, 8'h5A}) begin
      mismatched++;
      $display("FAIL midchar size: empty/data got %b/%h expected 0/5a", rd_empty, rd_data);
    end
    pop_one();
    send_char(8'h81, 8, 1'b0, e3, e4);
    compared++;
    if (rd_data !== 8'h81) begin
      mismatched++;
      $display("FAIL next boundary size: got %h expected 81", rd_data);
    end
    pop_one();
    drop_rts();
  endtask

  task automatic test_overflow();
    logic e3, e4;
    size_sel = 1'b1;
    raise_rts();
    for (int k = 1; k <= 5; k++) send_char(8'(k), 8, 1'b0, e3, e4);
    drop_rts();
    compared++;
    if ({rd_full, overflow} !== 2'b11) begin
      mismatched++;
      $display("FAIL overflow flags: full/overflow got %b%b expected 11", rd_full, overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      compared++;
      if (rd_data !== 8'(k)) begin
        mismatched++;
        $display("FAIL overflow pop %0d: got %h expected %h", k, rd_data, 8'(k));
      end
      pop_one();
    end
    compared++;
    if ({rd_empty, rd_full, overflow} !== 3'b101) begin
      mismatched++;
      $display("FAIL overflow drained: empty/full/ov got %b%b%b expected 101",
               rd_empty, rd_full, overflow);
    end
    pulse_clr();
    compared++;
    if (overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    logic       e3, e4;
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
    raise_rts();
    for (int k = 1; k <= 4; k++) send_char(8'(k), 8, 1'b0, e3, e4);
    send_char(8'h06, 8, 1'b1, e3, e4);
    drop_rts();
    compared++;
    if ({rd_full, overflow} !== 2'b10) begin
      mismatched++;
      $display("FAIL full+pop flags: full/overflow got %b%b expected 10", rd_full, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (rd_data !== exp_q[k]) begin
        mismatched++;
        $display("FAIL full+pop entry %0d: got %h expected %h", k, rd_data, exp_q[k]);
      end
      pop_one();
    end
    compared++;
    if (rd_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL full+pop drained: rd_empty got %b expected 1", rd_empty);
    end
  endtask

  task automatic test_reset_mid();
    logic       e3, e4;
    logic [7:0] d;
    d = 8'hFF;
    raise_rts();
    send_char(8'h77, 8, 1'b0, e3, e4);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    @(negedge clk) rst_n = 1'b0;
    #1;
    compared++;
    if ({rd_empty, rd_full, overflow, frame_err, rd_data} !== {4'b1000, 8'h00}) begin
      mismatched++;
      $display("FAIL reset mid: got e/f/ov/fe=%b%b%b%b data=%h, expected 1000 data=00",
               rd_empty, rd_full, overflow, frame_err, rd_data);
    end
    rts = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    compared++;
    if ({rd_empty, frame_err} !== 2'b10) begin
      mismatched++;
      $display("FAIL after reset release: empty/frame_err got %b%b expected 10", rd_empty, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_char8();
    test_char7_back_to_back();
    test_frame_err();
    test_size_midchar();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
